// File: rtl/btb_assoc_if.sv
// Fetch-lookup, resolved-branch update and flush-control signals of the branch target buffer.
interface btb_assoc_if;
  logic [31:0] fetch_pc;
  logic        fetch_hit;
  logic        fetch_taken;
  logic [31:0] fetch_target;
  logic        ex_update;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic        flush_req;
  logic        flush_busy;

  modport master (
    output fetch_pc, ex_update, ex_pc, ex_target, ex_taken, flush_req,
    input  fetch_hit, fetch_taken, fetch_target, flush_busy
  );

  modport slave (
    input  fetch_pc, ex_update, ex_pc, ex_target, ex_taken, flush_req,
    output fetch_hit, fetch_taken, fetch_target, flush_busy
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with round-robin replacement and a one-set-per-cycle flush.
// Optional BTB_HYST_EN adds a 2-bit saturating direction counter per way.
module btb_assoc #(
  parameter int SETS = 32,
  parameter int WAYS = 2
) (
  input logic       clk,
  input logic       rst,
  btb_assoc_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [WAYS-1:0]  valid   [SETS];
  logic [TAG_W-1:0] tag_mem [SETS][WAYS];
  logic [31:0]      tgt_mem [SETS][WAYS];
`ifdef BTB_HYST_EN
  logic [1:0]       ctr_mem [SETS][WAYS];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction
`endif

  logic [0:0]       state;
  logic [IDX_W-1:0] flush_cnt;
  logic             busy;

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit, e_inv;
  logic [WAY_W-1:0] f_way, e_way, inv_way, rr_way, victim;
  logic             upd_en, alloc;
  logic             unused_bits;

  assign unused_bits = ^{bus.fetch_pc[1:0], bus.ex_pc[1:0]};

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[31:IDX_W+2];
  assign e_idx = bus.ex_pc[IDX_W+1:2];
  assign e_tag = bus.ex_pc[31:IDX_W+2];

  always_comb begin
    f_hit = 1'b0;
    f_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[f_idx][w] && tag_mem[f_idx][w] == f_tag) begin
        f_hit = 1'b1;
        f_way = WAY_W'(w);
      end
    end
  end

  // Update side: hit way, and lowest invalid way (descending scan so the lowest wins)
  always_comb begin
    e_hit   = 1'b0;
    e_way   = '0;
    e_inv   = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[e_idx][w] && tag_mem[e_idx][w] == e_tag) begin
        e_hit = 1'b1;
        e_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[e_idx][w]) begin
        e_inv   = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign busy   = (state == FLUSH);
  assign upd_en = bus.ex_update & ~busy;
  assign alloc  = upd_en & ~e_hit & bus.ex_taken;
  assign victim = e_inv ? inv_way : rr_way;

  generate
    if (WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] rr [SETS];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else if (alloc && !e_inv) begin
          rr[e_idx] <= rr[e_idx] + 1'b1;
        end
      end

      assign rr_way = rr[e_idx];
    end else begin : g_one
      assign rr_way = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == IDX_W'(SETS - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else if (busy) begin
      valid[flush_cnt] <= '0;
    end else if (upd_en) begin
`ifndef BTB_HYST_EN
      if (e_hit && !bus.ex_taken) valid[e_idx][e_way] <= 1'b0;
`endif
      if (alloc) valid[e_idx][victim] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; they are meaningful only under a set valid bit
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (e_hit) begin
        if (bus.ex_taken) tgt_mem[e_idx][e_way] <= bus.ex_target;
`ifdef BTB_HYST_EN
        ctr_mem[e_idx][e_way] <= bus.ex_taken ? sat_inc(ctr_mem[e_idx][e_way])
                                              : sat_dec(ctr_mem[e_idx][e_way]);
`endif
      end else if (bus.ex_taken) begin
        tag_mem[e_idx][victim] <= e_tag;
        tgt_mem[e_idx][victim] <= bus.ex_target;
`ifdef BTB_HYST_EN
        ctr_mem[e_idx][victim] <= 2'd2;
`endif
      end
    end
  end

  assign bus.fetch_hit    = f_hit & ~busy;
  assign bus.fetch_target = tgt_mem[f_idx][f_way];
`ifdef BTB_HYST_EN
  assign bus.fetch_taken  = bus.fetch_hit & ctr_mem[f_idx][f_way][1];
`else
  assign bus.fetch_taken  = bus.fetch_hit;
`endif
  assign bus.flush_busy   = busy;
endmodule
